// File: rtl/bin_count_monitor_if.sv
// bin_count_monitor_if: q/qbar/load stream from the counter and the monitor's status outputs
interface bin_count_monitor_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic load;
  logic locked;
  logic err;
  logic compl_err;
  logic wrap;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  logic [1:0] state;
  modport master(output q, qbar, load, input locked, err, compl_err, wrap, err_count, wrap_count, state);
  modport slave(input q, qbar, load, output locked, err, compl_err, wrap, err_count, wrap_count, state);
endinterface

// File: rtl/bin_count_monitor.sv
// bin_count_monitor: locks onto a binary counter's q/qbar stream and flags breaks; BIN_COUNT_MONITOR_RESYNC_EN lets FAULT relock via SYNC
module bin_count_monitor #(
  parameter int WIDTH = 4,
  parameter int SYNC_LEN = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  bin_count_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;
  state_t state_q, state_d;
  logic [3:0] good_q, good_d;
  logic [WIDTH-1:0] samp_q;
  logic samp_en_q;
  logic err_q, err_d, compl_q, compl_d, wrap_q, wrap_d;
  logic [CNT_W-1:0] errc_q, errc_d, wrapc_q, wrapc_d;
  logic [WIDTH-1:0] expected;
  logic seq_ok, cmp_ok, ok;
  assign expected = samp_q + WIDTH'(samp_en_q);
  assign seq_ok = bus.q == expected;
  assign cmp_ok = bus.qbar == ~bus.q;
  assign ok = seq_ok && cmp_ok;
  always_comb begin
    state_d = state_q;
    good_d = good_q;
    err_d = 1'b0;
    compl_d = 1'b0;
    wrap_d = 1'b0;
    errc_d = errc_q;
    wrapc_d = wrapc_q;
    case (state_q)
      IDLE: state_d = SYNC;
      SYNC: begin
        good_d = ok ? good_q + 4'd1 : 4'd0;
        if (ok && good_d == 4'(SYNC_LEN)) state_d = TRACK;
      end
      TRACK: begin
        if (!ok) begin
          err_d = 1'b1;
          compl_d = !cmp_ok;
          errc_d = &errc_q ? errc_q : errc_q + CNT_W'(1);
          state_d = FAULT;
        end else if (samp_en_q && &samp_q) begin
          wrap_d = 1'b1;
          wrapc_d = wrapc_q + CNT_W'(1);
        end
      end
      FAULT: begin
`ifdef BIN_COUNT_MONITOR_RESYNC_EN
        state_d = SYNC;
        good_d = 4'd0;
`else
        state_d = FAULT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      good_q <= '0;
      samp_q <= '0;
      samp_en_q <= 1'b0;
      err_q <= 1'b0;
      compl_q <= 1'b0;
      wrap_q <= 1'b0;
      errc_q <= '0;
      wrapc_q <= '0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      samp_q <= bus.q;
      samp_en_q <= bus.load;
      err_q <= err_d;
      compl_q <= compl_d;
      wrap_q <= wrap_d;
      errc_q <= errc_d;
      wrapc_q <= wrapc_d;
    end
  end
  assign bus.state = state_q;
  assign bus.locked = state_q == TRACK;
  assign bus.err = err_q;
  assign bus.compl_err = compl_q;
  assign bus.wrap = wrap_q;
  assign bus.err_count = errc_q;
  assign bus.wrap_count = wrapc_q;
endmodule

// File: doc/bin_count_monitor.md
Name: bin_count_monitor

Overview:
- Receive-side checker for the free-running 4-bit binary counter's q/qbar outputs.
- Samples q, qbar and the counter's enable (load) every clock, locks onto the sequence, then flags sequence breaks and complement mismatches.
- Counts errors and wrap-arounds.
- Sits beside the counter in benches and on-chip as a built-in self-check.

Parameters:
- WIDTH, 4, counter width in bits.
- SYNC_LEN, 2, consecutive correct transitions required to lock (1..15).
- CNT_W, 8, width of err_count and wrap_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- q  input  WIDTH  observed counter value.
- qbar  input  WIDTH  observed complement output.
- load  input  1  the counter's enable: when 1 at edge k, q(k+1) = q(k)+1 mod 2^WIDTH; when 0, q(k+1) = q(k).
- locked  output  1  high while in TRACK.
- err  output  1  one-cycle pulse on any error detected in TRACK.
- compl_err  output  1  one-cycle pulse when qbar != ~q in TRACK.
- wrap  output  1  one-cycle pulse on all-ones to zero transition in TRACK.
- err_count  output  CNT_W  saturating error count.
- wrap_count  output  CNT_W  wrap count, modulo 2^CNT_W.
- state  output  2  IDLE=0, SYNC=1, TRACK=2, FAULT=3.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset: while reset=1 at an edge, state=IDLE, good_cnt=0, s_q=0, s_en=0, and all outputs are 0.
- Sampling:
  - Every edge, store s_q<=q and s_en<=load.
  - expected = s_q + s_en, computed modulo 2^WIDTH.
  - seq_ok = (q == expected).
  - cmp_ok = (qbar == ~q).
- State machine:
  - IDLE: capture the first sample, go to SYNC. No checks.
  - SYNC, seq_ok and cmp_ok: good_cnt++. When good_cnt reaches SYNC_LEN, go to TRACK and set locked=1 at the same edge.
  - SYNC, any mismatch: good_cnt=0, stay in SYNC. No err pulse, no count.
  - TRACK, both checks ok: stay.
  - TRACK, either check fails: err=1 for one cycle; compl_err=1 if !cmp_ok; err_count+1 (a single increment even if both fail), saturating at all-ones. Go to FAULT, locked=0.
  - TRACK wrap: s_q all ones, s_en=1, q=0 and checks ok → wrap=1 for one cycle, wrap_count+1.
  - FAULT: behaviour set by the optional feature.
- Latency: all outputs are registered. A bad value present before edge k produces err high from edge k until edge k+1.
- Pulses (err, compl_err, wrap) default to 0 in every cycle not explicitly pulsing.
- Simultaneous events: a wrap with an error in the same cycle is an error only; wrap does not pulse and wrap_count is unchanged.
- Reset mid-operation: reset overrides every transition in the same cycle; counters clear.
- load=0 with q unchanged is a match; load=0 with q changed is an error.

Optional Feature:
- Macro: BIN_COUNT_MONITOR_RESYNC_EN.
- Defined: FAULT lasts one cycle, then returns to SYNC with good_cnt=0. The monitor relocks automatically; err_count keeps accumulating.
- Undefined: FAULT is terminal until reset. No further err, compl_err or wrap pulses, and counters freeze.

Test Plan:
- Hold reset 50 cycles, release, then drive the counter from 0 with load=1 → state goes 1 after the first edge; locked=1 after the 3rd edge (q=2 sampled); err_count=0.
- Free-run 40 cycles after lock → exactly 2 wrap pulses, each at the q 15→0 transition; wrap_count=2; err=0 throughout.
- In TRACK, jump q 5→7 → err pulses one cycle, compl_err=0, err_count=1, state=3, locked=0. Without the macro, state stays 3 for the following 20 cycles.
- In TRACK, drive qbar = ~q ^ 4'b0001 for one cycle with the q sequence correct → err=1 and compl_err=1 together, err_count=1.
- In TRACK, load=0 for 5 cycles with q held at 9 → no err, locked stays 1. Then load=0 with q changing 9→10 → err=1.
- With BIN_COUNT_MONITOR_RESYNC_EN, inject an error → FAULT for 1 cycle, SYNC, locked again 2 good transitions later. A second error gives err_count=2. Reset asserted mid-TRACK → all outputs 0 after that edge.
